key_command_gen: RTL

KEY_COMMAND_GEN -- requirements
Module: key_command_gen

---
 rtl/key_command_gen.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/key_command_gen.sv
// Debounced four-button front panel that emits one-hot command pulses to the exhaust FSM.
// Define KEY_LONGPRESS_EN to build the menu long-press detector driving long_menu.
module key_command_gen #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 200000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_menu,
    input  logic       btn_l1,
    input  logic       btn_l2,
    input  logic       btn_l3,
    input  logic       is_on,
    input  logic       countdown_active,
    output logic       menu_key,
    output logic       level1_key,
    output logic       level2_key,
    output logic       level3_key,
    output logic       hurricane_used,
    output logic [7:0] key_count,
    output logic       long_menu
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    if (DEB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
        $error("key_command_gen: DEB_CYCLES and LONG_CYCLES must be at least 1");
    end

    // Bit order everywhere: [3]=menu, [2]=l1, [1]=l2, [0]=l3 (descending priority).
    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    stable_q, stable_prev_q;
    logic [DW-1:0] deb_cnt_q [4];
    logic [3:0]    cand;
    logic [3:0]    key_d, key_q;
    logic          is_on_q;
    logic          hurricane_used_q;
    logic [7:0]    key_count_q;

    assign raw = {btn_menu, btn_l1, btn_l2, btn_l3};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q       <= raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] == stable_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DW'(DEB_CYCLES - 1)) begin
                    stable_q[i]  <= ~stable_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign cand = stable_q & ~stable_prev_q;

    // Every filter (power, countdown, hurricane) masks a priority suffix, so
    // filtering before or after arbitration gives the same winner.
    always_comb begin
        key_d = '0;
        if (is_on) begin
            if (cand[3]) begin
                key_d[3] = 1'b1;
            end else if (!countdown_active) begin
                if (cand[2])                          key_d[2] = 1'b1;
                else if (cand[1])                     key_d[1] = 1'b1;
                else if (cand[0] && !hurricane_used_q) key_d[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q            <= '0;
            is_on_q          <= 1'b0;
            hurricane_used_q <= 1'b0;
            key_count_q      <= '0;
        end else begin
            key_q   <= key_d;
            is_on_q <= is_on;
            if (is_on_q && !is_on) hurricane_used_q <= 1'b0;
            else                   hurricane_used_q <= hurricane_used_q | key_q[0];
            key_count_q <= key_count_q + {7'd0, |key_q};
        end
    end

    assign menu_key       = key_q[3];
    assign level1_key     = key_q[2];
    assign level2_key     = key_q[1];
    assign level3_key     = key_q[0];
    assign hurricane_used = hurricane_used_q;
    assign key_count      = key_count_q;

`ifdef KEY_LONGPRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);

    logic [LW-1:0] long_cnt_q;
    logic          long_fired_q;
    logic          long_menu_q;

    // One long pulse per press: long_fired_q re-arms only once menu settles low.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt_q   <= '0;
            long_fired_q <= 1'b0;
            long_menu_q  <= 1'b0;
        end else begin
            long_menu_q <= 1'b0;
            if (!stable_q[3]) begin
                long_cnt_q   <= '0;
                long_fired_q <= 1'b0;
            end else if (!is_on) begin
                long_cnt_q <= '0;
            end else if (!long_fired_q) begin
                if (long_cnt_q == LW'(LONG_CYCLES - 1)) begin
                    long_menu_q  <= 1'b1;
                    long_fired_q <= 1'b1;
                    long_cnt_q   <= '0;
                end else begin
                    long_cnt_q <= long_cnt_q + 1'b1;
                end
            end
        end
    end

    assign long_menu = long_menu_q;
`else
    assign long_menu = 1'b0;
`endif

endmodule
